// File: rtl/sprite_blitter.sv
// Chip-8 framebuffer writer: XOR sprite draw with collision detect (DRW) and full clear (CLS)
// against a 512x16 synchronous framebuffer RAM; sprite bytes fetched over a req/ack port.
module sprite_blitter (
  input  logic        clk,
  input  logic        res,
  input  logic        start,
  input  logic        cls,
  input  logic        hires,
  input  logic [6:0]  x,
  input  logic [5:0]  y,
  input  logic [3:0]  n,
  input  logic [11:0] spriteAddr,
  output logic [11:0] memAddr,
  output logic        memReq,
  input  logic        memAck,
  input  logic [7:0]  memData,
  output logic [8:0]  fbAddr,
  output logic        fbWe,
  output logic [15:0] fbWrData,
  input  logic [15:0] fbRdData,
  output logic        busy,
  output logic        done,
  output logic        collision
);

  typedef enum logic [3:0] {
    IDLE, CLEAR, FETCH, RD0, WR0, RD1, WR1, NEXTROW, DONE
  } state_t;

  state_t      state_q, state_d;
  logic        hires_q, hires_d;
  logic        wide_q, wide_d;
  logic [6:0]  xw_q, xw_d;
  logic [5:0]  yw_q, yw_d;
  logic [4:0]  rows_q, rows_d;
  logic [11:0] base_q, base_d;
  logic [4:0]  row_q, row_d;
  logic [15:0] spr_q, spr_d;
  logic        hi_done_q, hi_done_d;
  logic [8:0]  clr_q, clr_d;
  logic        coll_q, coll_d;

  logic [15:0] spr_new;
  logic [31:0] shift_cur, shift_new;
  logic [15:0] mask0, mask1, new_mask0, new_mask1;
  logic        right_clip;
  logic [5:0]  row_y;
  logic [8:0]  word0, word1;
  logic [4:0]  row_inc;
  logic [6:0]  y_inc, height;
  logic        row_last;
  logic [11:0] fetch_addr;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q   <= IDLE;
      hires_q   <= 1'b0;
      wide_q    <= 1'b0;
      xw_q      <= '0;
      yw_q      <= '0;
      rows_q    <= '0;
      base_q    <= '0;
      row_q     <= '0;
      spr_q     <= '0;
      hi_done_q <= 1'b0;
      clr_q     <= '0;
      coll_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hires_q   <= hires_d;
      wide_q    <= wide_d;
      xw_q      <= xw_d;
      yw_q      <= yw_d;
      rows_q    <= rows_d;
      base_q    <= base_d;
      row_q     <= row_d;
      spr_q     <= spr_d;
      hi_done_q <= hi_done_d;
      clr_q     <= clr_d;
      coll_q    <= coll_d;
    end
  end

  // Row data as it will look once the byte on memData is captured; lets FETCH pick
  // the first word pass without spending a cycle on the freshly stored row.
  always_comb begin
    spr_new    = wide_q ? {spr_q[15:8], memData} : {memData, 8'h00};
    shift_cur  = {spr_q, 16'h0000} >> xw_q[3:0];
    shift_new  = {spr_new, 16'h0000} >> xw_q[3:0];
    mask0      = shift_cur[31:16];
    mask1      = shift_cur[15:0];
    new_mask0  = shift_new[31:16];
    new_mask1  = shift_new[15:0];
    right_clip = hires_q ? (xw_q[6:4] == 3'd7) : (xw_q[5:4] == 2'd3);
    row_y      = yw_q + {1'b0, row_q};
    word0      = hires_q ? ({row_y, 3'b000} + {6'b0, xw_q[6:4]})
                         : ({2'b00, row_y[4:0], 2'b00} + {7'b0, xw_q[5:4]});
    word1      = word0 + 9'd1;
    row_inc    = row_q + 5'd1;
    y_inc      = {1'b0, yw_q} + {2'b00, row_inc};
    height     = hires_q ? 7'd64 : 7'd32;
    row_last   = (row_inc >= rows_q) || (y_inc >= height);
    fetch_addr = wide_q ? (base_q + {6'b0, row_q, 1'b0} + {11'b0, hi_done_q})
                        : (base_q + {7'b0, row_q});
  end

  always_comb begin
    state_d   = state_q;
    hires_d   = hires_q;
    wide_d    = wide_q;
    xw_d      = xw_q;
    yw_d      = yw_q;
    rows_d    = rows_q;
    base_d    = base_q;
    row_d     = row_q;
    spr_d     = spr_q;
    hi_done_d = hi_done_q;
    clr_d     = clr_q;
    coll_d    = coll_q;
    memAddr   = '0;
    memReq    = 1'b0;
    fbAddr    = '0;
    fbWe      = 1'b0;
    fbWrData  = '0;
    busy      = (state_q != IDLE) && (state_q != DONE);
    done      = (state_q == DONE);
    collision = coll_q;

    unique case (state_q)
      IDLE: begin
        if (cls) begin
          clr_d   = '0;
          coll_d  = 1'b0;
          state_d = CLEAR;
        end else if (start) begin
          hires_d   = hires;
          wide_d    = hires && (n == 4'd0);
          xw_d      = hires ? x : {1'b0, x[5:0]};
          yw_d      = hires ? y : {1'b0, y[4:0]};
          rows_d    = (hires && (n == 4'd0)) ? 5'd16 : {1'b0, n};
          base_d    = spriteAddr;
          row_d     = '0;
          hi_done_d = 1'b0;
          coll_d    = 1'b0;
          state_d   = (!hires && (n == 4'd0)) ? NEXTROW : FETCH;
        end
      end
      CLEAR: begin
        fbAddr = clr_q;
        fbWe   = 1'b1;
        clr_d  = clr_q + 9'd1;
        if (clr_q == 9'd511) state_d = DONE;
      end
      FETCH: begin
        memReq  = 1'b1;
        memAddr = fetch_addr;
        if (memAck) begin
          if (wide_q && !hi_done_q) begin
            spr_d     = {memData, 8'h00};
            hi_done_d = 1'b1;
          end else begin
            spr_d     = spr_new;
            hi_done_d = 1'b0;
            if (new_mask0 != 16'h0)                    state_d = RD0;
            else if (new_mask1 != 16'h0 && !right_clip) state_d = RD1;
            else                                        state_d = NEXTROW;
          end
        end
      end
      RD0: begin
        fbAddr  = word0;
        state_d = WR0;
      end
      WR0: begin
        fbAddr   = word0;
        fbWe     = 1'b1;
        fbWrData = fbRdData ^ mask0;
        coll_d   = coll_q | (|(fbRdData & mask0));
        if (mask1 != 16'h0 && !right_clip) begin
          state_d = RD1;
        end else begin
          row_d   = row_inc;
          state_d = row_last ? DONE : FETCH;
        end
      end
      RD1: begin
        fbAddr  = word1;
        state_d = WR1;
      end
      WR1: begin
        fbAddr   = word1;
        fbWe     = 1'b1;
        fbWrData = fbRdData ^ mask1;
        coll_d   = coll_q | (|(fbRdData & mask1));
        row_d    = row_inc;
        state_d  = row_last ? DONE : FETCH;
      end
      NEXTROW: begin
        row_d   = row_inc;
        state_d = row_last ? DONE : FETCH;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter: hand-computed vector table, corner-case sequences, and random
// draws checked against a pixel-level reference model of the framebuffer.
module tb_sprite_blitter;

  logic        clk = 1'b0;
  logic        res, start, cls, hires;
  logic [6:0]  x;
  logic [5:0]  y;
  logic [3:0]  n;
  logic [11:0] spriteAddr;
  logic [11:0] memAddr;
  logic        memReq, memAck;
  logic [7:0]  memData;
  logic [8:0]  fbAddr;
  logic        fbWe;
  logic [15:0] fbWrData, fbRdData;
  logic        busy, done, collision;

  bit [7:0]  smem   [4096];
  bit [15:0] fb_mem [512];
  bit [15:0] ref_fb [512];
  int        ack_delay = 0;
  int        wait_cnt;
  int        errors = 0;
  int        checks = 0;

  typedef struct { logic [8:0] a; logic [15:0] d; } wr_t;
  wr_t         wr_log[$];
  logic [11:0] fetch_log[$];
  logic [11:0] req_log[$];
  int          wr_base, f_base, r_base;

  typedef struct {
    bit          hires;
    logic [6:0]  x;
    logic [5:0]  y;
    logic [3:0]  n;
    logic [11:0] i;
    int          nwr;
    logic [8:0]  a_first;
    logic [15:0] d_first;
    logic [8:0]  a_last;
    logic [15:0] d_last;
    bit          coll;
    int          dcyc;
    int          nfetch;
    logic [11:0] f_last;
  } vec_t;
  vec_t vec[10];

  sprite_blitter dut (
    .clk(clk), .res(res), .start(start), .cls(cls), .hires(hires),
    .x(x), .y(y), .n(n), .spriteAddr(spriteAddr),
    .memAddr(memAddr), .memReq(memReq), .memAck(memAck), .memData(memData),
    .fbAddr(fbAddr), .fbWe(fbWe), .fbWrData(fbWrData), .fbRdData(fbRdData),
    .busy(busy), .done(done), .collision(collision)
  );

  always #5 clk = ~clk;

  assign memAck  = memReq && (wait_cnt >= ack_delay);
  assign memData = memAck ? smem[memAddr] : 8'h00;

  always @(posedge clk or posedge res)
    if (res) wait_cnt <= 0;
    else if (memReq && !memAck) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;

  always @(posedge clk) begin
    if (fbWe) fb_mem[fbAddr] <= fbWrData;
    fbRdData <= fb_mem[fbAddr];
  end

  always @(negedge clk) begin
    if (fbWe) wr_log.push_back('{fbAddr, fbWrData});
    if (memReq) req_log.push_back(memAddr);
    if (memReq && memAck) fetch_log.push_back(memAddr);
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_op(input bit c, input bit s, input bit h, input logic [6:0] xi,
                        input logic [5:0] yi, input logic [3:0] ni, input logic [11:0] ii,
                        output int dcyc, output bit b1, output bit bdone);
    wr_base = wr_log.size();
    f_base  = fetch_log.size();
    r_base  = req_log.size();
    cls = c; start = s; hires = h; x = xi; y = yi; n = ni; spriteAddr = ii;
    @(posedge clk); #1;
    cls = 1'b0; start = 1'b0;
    b1 = busy;
    dcyc = -1;
    bdone = 1'b1;
    for (int cyc = 1; cyc < 4000; cyc++) begin
      if (done) begin
        dcyc  = cyc;
        bdone = busy;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic model_draw(input bit h, input int xi, input int yi, input int ni,
                            input int ii, output bit coll);
    int wdt, hgt, stride, xx, yy, rows, cols, py, px, wd, bt;
    bit wide;
    logic [7:0] bv;
    wdt = h ? 128 : 64;
    hgt = h ? 64 : 32;
    stride = h ? 8 : 4;
    xx = xi % wdt;
    yy = yi % hgt;
    wide = h && (ni == 0);
    rows = wide ? 16 : ni;
    cols = wide ? 16 : 8;
    coll = 1'b0;
    for (int r = 0; r < rows; r++) begin
      py = yy + r;
      if (py >= hgt) break;
      for (int c = 0; c < cols; c++) begin
        bv = wide ? smem[(ii + 2 * r + c / 8) % 4096] : smem[(ii + r) % 4096];
        if (!bv[7 - c % 8]) continue;
        px = xx + c;
        if (px >= wdt) continue;
        wd = py * stride + px / 16;
        bt = 15 - px % 16;
        if (ref_fb[wd][bt]) coll = 1'b1;
        ref_fb[wd][bt] = ~ref_fb[wd][bt];
      end
    end
  endtask

  function automatic int fb_diff();
    int cnt = 0;
    for (int k = 0; k < 512; k++) if (fb_mem[k] != ref_fb[k]) cnt++;
    return cnt;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  dcyc, nw, nf, bad, nz;
    bit  b1, bdone, mcoll;
    bit  h;
    int  xi, yi, ni, ii;

    vec[0] = '{0, 0,   0,  1, 12'h200, 1, 0,   16'hF000, 0,   16'hF000, 0, 4,  1, 12'h200};
    vec[1] = '{0, 0,   0,  1, 12'h200, 1, 0,   16'h0000, 0,   16'h0000, 1, 4,  1, 12'h200};
    vec[2] = '{0, 12,  1,  1, 12'h210, 2, 4,   16'h000F, 5,   16'hF000, 0, 6,  1, 12'h210};
    vec[3] = '{0, 60,  31, 2, 12'h220, 1, 127, 16'h000F, 127, 16'h000F, 0, 4,  1, 12'h220};
    vec[4] = '{0, 70,  0,  1, 12'h230, 1, 0,   16'h0200, 0,   16'h0200, 0, 4,  1, 12'h230};
    vec[5] = '{1, 8,   62, 0, 12'h240, 4, 496, 16'h00FF, 505, 16'hFF00, 0, 13, 4, 12'h243};
    vec[6] = '{0, 6,   0,  1, 12'h230, 1, 0,   16'h0000, 0,   16'h0000, 1, 4,  1, 12'h230};
    vec[7] = '{0, 5,   5,  0, 12'h270, 0, 0,   16'h0000, 0,   16'h0000, 0, 2,  0, 12'h000};
    vec[8] = '{0, 0,   5,  1, 12'h250, 0, 0,   16'h0000, 0,   16'h0000, 0, 3,  1, 12'h250};
    vec[9] = '{1, 127, 0,  1, 12'h260, 1, 7,   16'h0001, 7,   16'h0001, 0, 4,  1, 12'h260};

    for (int k = 0; k < 4096; k++) smem[k] = 8'($urandom);
    smem[12'h200] = 8'hF0;
    smem[12'h210] = 8'hFF;
    smem[12'h220] = 8'hFF; smem[12'h221] = 8'hFF;
    smem[12'h230] = 8'h80;
    for (int k = 0; k < 4; k++) smem[12'h240 + k] = 8'hFF;
    smem[12'h250] = 8'h00;
    smem[12'h260] = 8'hC0;

    res = 1'b0; start = 1'b0; cls = 1'b0; hires = 1'b0;
    x = '0; y = '0; n = '0; spriteAddr = '0;
    #2 res = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_collision", collision, 0);
    chk("rst_memReq", memReq, 0);
    chk("rst_memAddr", memAddr, 0);
    chk("rst_fbWe", fbWe, 0);
    chk("rst_fbAddr", fbAddr, 0);
    chk("rst_fbWrData", fbWrData, 0);
    @(posedge clk); @(posedge clk); #1;
    res = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      run_op(0, 1, vec[i].hires, vec[i].x, vec[i].y, vec[i].n, vec[i].i, dcyc, b1, bdone);
      nw = wr_log.size() - wr_base;
      nf = fetch_log.size() - f_base;
      chk($sformatf("v%0d_nwr", i), nw, vec[i].nwr);
      if (vec[i].nwr > 0 && nw > 0) begin
        chk($sformatf("v%0d_first_addr", i), wr_log[wr_base].a, vec[i].a_first);
        chk($sformatf("v%0d_first_data", i), wr_log[wr_base].d, vec[i].d_first);
        chk($sformatf("v%0d_last_addr", i), wr_log[wr_log.size() - 1].a, vec[i].a_last);
        chk($sformatf("v%0d_last_data", i), wr_log[wr_log.size() - 1].d, vec[i].d_last);
      end
      chk($sformatf("v%0d_collision", i), collision, vec[i].coll);
      chk($sformatf("v%0d_done_cycle", i), dcyc, vec[i].dcyc);
      chk($sformatf("v%0d_busy_c1", i), b1, 1);
      chk($sformatf("v%0d_busy_at_done", i), bdone, 0);
      chk($sformatf("v%0d_nfetch", i), nf, vec[i].nfetch);
      if (vec[i].nfetch > 0 && nf > 0) begin
        chk($sformatf("v%0d_first_fetch", i), fetch_log[f_base], vec[i].i);
        chk($sformatf("v%0d_last_fetch", i), fetch_log[fetch_log.size() - 1], vec[i].f_last);
      end
    end

    // Slow memory: the request and its address must hold until the ack arrives.
    ack_delay = 3;
    run_op(0, 1, 0, 12, 2, 1, 12'h200, dcyc, b1, bdone);
    ack_delay = 0;
    bad = 0;
    for (int k = r_base; k < req_log.size(); k++) if (req_log[k] != 12'h200) bad++;
    chk("slow_req_cycles", req_log.size() - r_base, 4);
    chk("slow_req_addr_changes", bad, 0);
    chk("slow_done_cycle", dcyc, 7);
    chk("slow_nwr", wr_log.size() - wr_base, 1);
    if (wr_log.size() > wr_base) begin
      chk("slow_wr_addr", wr_log[wr_base].a, 8);
      chk("slow_wr_data", wr_log[wr_base].d, 16'h000F);
    end

    run_op(0, 1, 1, 127, 0, 1, 12'h260, dcyc, b1, bdone);
    chk("redraw_collision", collision, 1);
    chk("redraw_data", fb_mem[7], 16'h0000);

    // Reset in the middle of a hires draw, while a write is in flight.
    start = 1'b1; hires = 1'b1; x = 7'd8; y = 6'd10; n = 4'd0; spriteAddr = 12'h240;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk("midraw_busy", busy, 1);
    chk("midraw_fbWe", fbWe, 1);
    #2 res = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_memReq", memReq, 0);
    chk("arst_memAddr", memAddr, 0);
    chk("arst_fbWe", fbWe, 0);
    chk("arst_fbAddr", fbAddr, 0);
    chk("arst_fbWrData", fbWrData, 0);
    chk("arst_done", done, 0);
    chk("arst_collision", collision, 0);
    #1 res = 1'b0;
    @(posedge clk); #1;
    run_op(0, 1, 0, 0, 0, 0, 12'h000, dcyc, b1, bdone);
    chk("post_rst_done_cycle", dcyc, 2);
    chk("post_rst_busy_c1", b1, 1);
    chk("post_rst_collision", collision, 0);

    run_op(0, 1, 1, 127, 0, 1, 12'h260, dcyc, b1, bdone);
    run_op(0, 1, 1, 127, 0, 1, 12'h260, dcyc, b1, bdone);
    chk("pre_cls_collision", collision, 1);

    // Clear with start raised in the same cycle: clear wins, start is dropped.
    run_op(1, 1, 1, 0, 0, 1, 12'h200, dcyc, b1, bdone);
    bad = 0;
    if (wr_log.size() - wr_base == 512)
      for (int k = 0; k < 512; k++)
        if (wr_log[wr_base + k].a != 9'(k) || wr_log[wr_base + k].d != 16'h0) bad++;
    nz = 0;
    for (int k = 0; k < 512; k++) if (fb_mem[k] != 16'h0) nz++;
    chk("cls_nwr", wr_log.size() - wr_base, 512);
    chk("cls_order_bad", bad, 0);
    chk("cls_nonzero_words", nz, 0);
    chk("cls_done_cycle", dcyc, 513);
    chk("cls_busy_c1", b1, 1);
    chk("cls_busy_at_done", bdone, 0);
    chk("cls_collision", collision, 0);
    chk("cls_mem_reqs", req_log.size() - r_base, 0);

    for (int k = 0; k < 512; k++) ref_fb[k] = 16'h0;
    for (int it = 0; it < 40; it++) begin
      h  = 1'($urandom_range(0, 1));
      xi = $urandom_range(0, 127);
      yi = $urandom_range(0, 63);
      ni = $urandom_range(0, 15);
      ii = $urandom_range(0, 4095);
      ack_delay = $urandom_range(0, 2);
      if (it % 13 == 12) begin
        run_op(1, 0, h, 7'(xi), 6'(yi), 4'(ni), 12'(ii), dcyc, b1, bdone);
        for (int k = 0; k < 512; k++) ref_fb[k] = 16'h0;
        mcoll = 1'b0;
      end else begin
        model_draw(h, xi, yi, ni, ii, mcoll);
        run_op(0, 1, h, 7'(xi), 6'(yi), 4'(ni), 12'(ii), dcyc, b1, bdone);
      end
      chk($sformatf("rnd%0d_done_seen", it), (dcyc > 0) ? 1 : 0, 1);
      chk($sformatf("rnd%0d_collision", it), collision, mcoll);
      chk($sformatf("rnd%0d_fb_words_differing", it), fb_diff(), 0);
    end
    ack_delay = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Framebuffer writer for the Chip-8 core: executes DRW (XOR sprite draw with collision detect) and CLS (clear) against the 512×16-bit framebuffer RAM that the display scanner reads. It fetches sprite bytes from main memory over a req/ack port, then read-modify-writes framebuffer words. It sits between the CPU execute stage and the framebuffer RAM's write port. Word bit 15 is the leftmost pixel; line stride is 4 words in lores (64×32) and 8 words in hires (128×64).

## Interface
- No parameters.
- clk  in  1  system clock
- res  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle DRW request; sampled only in IDLE
- cls  in  1  one-cycle clear request; sampled only in IDLE; wins over start
- hires  in  1  mode, latched at accept
- x  in  7  sprite X, latched at accept
- y  in  6  sprite Y, latched at accept
- n  in  4  sprite rows; n=0 with hires = 16×16 sprite; n=0 lores = no-op draw
- spriteAddr  in  12  I register, latched at accept
- memAddr  out  12  sprite byte address
- memReq  out  1  byte request; held until memAck
- memAck  in  1  memData valid this cycle
- memData  in  8  sprite byte
- fbAddr  out  9  framebuffer word address
- fbWe  out  1  write enable
- fbWrData  out  16  write data
- fbRdData  in  16  read data, valid one cycle after fbAddr (sync RAM)
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- collision  out  1  result of last DRW; held until next accept

## Operation
- States: IDLE, CLEAR, FETCH, RD0, WR0, RD1, WR1, NEXTROW, DONE.
- Accept: latch inputs; X wraps to x mod width, Y to y mod height; clear collision; row r=0.
- Sprite width w=16 when hires&&n==0 (16 rows, 2 bytes/row at I+2r, I+2r+1, high byte first), else w=8 (n rows, byte at I+r, placed in bits 15:8 of 16-bit row s). memAddr wraps mod 4096.
- FETCH: memReq=1 with memAddr until memAck; capture byte; repeat for second byte if w=16.
- Mask: {s,16'h0} >> X[3:0]; mask0 = bits 31:16, mask1 = bits 15:0.
- Row address base = (Y+r)·stride; word0 = base + X[6:4]; word1 = word0+1.
- RD0: fbAddr=word0, fbWe=0. WR0: fbAddr=word0, fbWe=1, fbWrData=fbRdData^mask0; collision |= |(fbRdData&mask0). RD1/WR1 same for word1.
- Word pass skipped iff its mask is 0; word1 also skipped if X[6:4]+1 ≥ stride (right clip, no wrap).
- NEXTROW: r++; finish when r = row count or Y+r ≥ height (bottom clip).
- CLEAR: writes 16'h0000 to addresses 0..511 in order, one per cycle, regardless of hires; collision forced 0.
- DONE: done=1 one cycle, then IDLE.
- start/cls while busy: ignored. Reset mid-operation: abort immediately, RAM left partially modified.

## Timing
- Reset values: memAddr=0, memReq=0, fbAddr=0, fbWe=0, fbWrData=0, busy=0, done=0, collision=0; state IDLE.
- Accept at cycle 0 → busy=1 from cycle 1, first memReq in cycle 1 (DRW) or first write in cycle 1 (CLS).
- memAck in cycle k → next memReq or RD0 in k+1; zero-wait ack gives 1 cycle/byte.
- Each word pass = 2 cycles; fbWe asserted only in WR0/WR1.
- CLS: 512 write cycles, done in cycle 513, busy=0 in the same cycle done=1.
- DRW: done in cycle after last WR (or after last NEXTROW); busy low with done; collision stable from done onward.
- Lores n=0: FETCH skipped, done in cycle 2, collision 0.

## Test plan
- Reset: assert res asynchronously mid-draw → all outputs 0 without waiting for clk edge; start next cycle accepted normally.
- Lores x=0 y=0 n=1, I=0x200 holding 0xF0, RAM zero → one write addr 0 data F000, collision 0; repeat → addr 0 data 0000, collision 1.
- Lores x=12 y=1 n=1 byte 0xFF → writes addr 4 data 000F, addr 5 data F000; memAck delayed 3 cycles → memReq held 4 cycles, addr 0x200 stable.
- Clip/wrap: lores x=60 y=31 n=2 byte 0xFF → single write addr 127 data 000F, no row-32 access; x=70 y=0 byte 0x80 → write addr 0 data 0200.
- Hires n=0 x=8 y=62 bytes 0xFFFF → memAddr I..I+3 only, writes addrs 496,497,504,505 with 00FF/FF00 each, done, busy low.
- CLS with start high in same cycle → 512 zero writes addrs 0..511, start ignored, done at cycle 513, collision 0.
